// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the ecap5 processor datapath.
// Holds the arbiter FSM encoding and the master identifiers used for last_grant.
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2
    } arb_state_t;

    localparam logic ARB_MASTER_IF = 1'b0;
    localparam logic ARB_MASTER_LS = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master pipelined Wishbone arbiter: fetch (IF) and loadstore (LS) share one slave port.
// The grant is held per bus cycle, outstanding accepts are counted, and ties alternate.
module bus_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] if_wb_adr_i,
    input  logic [31:0] if_wb_dat_i,
    input  logic        if_wb_we_i,
    input  logic [3:0]  if_wb_sel_i,
    input  logic        if_wb_stb_i,
    input  logic        if_wb_cyc_i,
    output logic [31:0] if_wb_dat_o,
    output logic        if_wb_ack_o,
    output logic        if_wb_stall_o,

    input  logic [31:0] ls_wb_adr_i,
    input  logic [31:0] ls_wb_dat_i,
    input  logic        ls_wb_we_i,
    input  logic [3:0]  ls_wb_sel_i,
    input  logic        ls_wb_stb_i,
    input  logic        ls_wb_cyc_i,
    output logic [31:0] ls_wb_dat_o,
    output logic        ls_wb_ack_o,
    output logic        ls_wb_stall_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic accept;
    logic ack_cnt;

    assign full    = (count_q == CNT_MAX);
    assign accept  = wb_stb_o & ~wb_stall_i;
    // Acks at count 0 or outside a grant belong to nothing we issued.
    assign ack_cnt = wb_ack_i & (state_q != IDLE) & (count_q != '0);

    assign if_wb_dat_o = wb_dat_i;
    assign ls_wb_dat_o = wb_dat_i;

    always_comb begin
        wb_adr_o      = if_wb_adr_i;
        wb_dat_o      = if_wb_dat_i;
        wb_we_o       = if_wb_we_i;
        wb_sel_o      = if_wb_sel_i;
        wb_cyc_o      = 1'b0;
        wb_stb_o      = 1'b0;
        if_wb_stall_o = 1'b1;
        ls_wb_stall_o = 1'b1;
        if_wb_ack_o   = 1'b0;
        ls_wb_ack_o   = 1'b0;
        case (state_q)
            GRANT_IF: begin
                wb_cyc_o      = if_wb_cyc_i;
                wb_stb_o      = if_wb_stb_i & ~full;
                if_wb_stall_o = wb_stall_i | full;
                if_wb_ack_o   = wb_ack_i;
            end
            GRANT_LS: begin
                wb_adr_o      = ls_wb_adr_i;
                wb_dat_o      = ls_wb_dat_i;
                wb_we_o       = ls_wb_we_i;
                wb_sel_o      = ls_wb_sel_i;
                wb_cyc_o      = ls_wb_cyc_i;
                wb_stb_o      = ls_wb_stb_i & ~full;
                ls_wb_stall_o = wb_stall_i | full;
                ls_wb_ack_o   = wb_ack_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        if (accept && !ack_cnt) begin
            count_d = count_q + CNT_ONE;
        end else if (ack_cnt && !accept) begin
            count_d = count_q - CNT_ONE;
        end
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (if_wb_cyc_i && ls_wb_cyc_i) begin
                    if (last_grant_q == ARB_MASTER_IF) begin
                        state_d      = GRANT_LS;
                        last_grant_d = ARB_MASTER_LS;
                    end else begin
                        state_d      = GRANT_IF;
                        last_grant_d = ARB_MASTER_IF;
                    end
                end else if (if_wb_cyc_i) begin
                    state_d      = GRANT_IF;
                    last_grant_d = ARB_MASTER_IF;
                end else if (ls_wb_cyc_i) begin
                    state_d      = GRANT_LS;
                    last_grant_d = ARB_MASTER_LS;
                end
            end
            // Dropping cyc releases the bus; anything still outstanding is abandoned.
            GRANT_IF: begin
                if (!if_wb_cyc_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            GRANT_LS: begin
                if (!ls_wb_cyc_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= ARB_MASTER_IF;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with MAX_OUTSTANDING = 4.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_bus_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] if_wb_adr_i, if_wb_dat_i, ls_wb_adr_i, ls_wb_dat_i;
    logic        if_wb_we_i, if_wb_stb_i, if_wb_cyc_i;
    logic        ls_wb_we_i, ls_wb_stb_i, ls_wb_cyc_i;
    logic [3:0]  if_wb_sel_i, ls_wb_sel_i;
    logic [31:0] if_wb_dat_o, ls_wb_dat_o;
    logic        if_wb_ack_o, if_wb_stall_o, ls_wb_ack_o, ls_wb_stall_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_stall_i;

    int checks;
    int errors;
    int testcase;

    bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_wb_adr_i(if_wb_adr_i), .if_wb_dat_i(if_wb_dat_i), .if_wb_we_i(if_wb_we_i),
        .if_wb_sel_i(if_wb_sel_i), .if_wb_stb_i(if_wb_stb_i), .if_wb_cyc_i(if_wb_cyc_i),
        .if_wb_dat_o(if_wb_dat_o), .if_wb_ack_o(if_wb_ack_o), .if_wb_stall_o(if_wb_stall_o),
        .ls_wb_adr_i(ls_wb_adr_i), .ls_wb_dat_i(ls_wb_dat_i), .ls_wb_we_i(ls_wb_we_i),
        .ls_wb_sel_i(ls_wb_sel_i), .ls_wb_stb_i(ls_wb_stb_i), .ls_wb_cyc_i(ls_wb_cyc_i),
        .ls_wb_dat_o(ls_wb_dat_o), .ls_wb_ack_o(ls_wb_ack_o), .ls_wb_stall_o(ls_wb_stall_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL tc%0d %s: got %h expected %h", testcase, tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_wb_cyc_i = 0; if_wb_stb_i = 0; ls_wb_cyc_i = 0; ls_wb_stb_i = 0;
        wb_ack_i = 0; wb_stall_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        step();
        rst_i = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cyc"}, {31'd0, wb_cyc_o}, 0);
        chk({tag, ".stb"}, {31'd0, wb_stb_o}, 0);
        chk({tag, ".if_stall"}, {31'd0, if_wb_stall_o}, 1);
        chk({tag, ".ls_stall"}, {31'd0, ls_wb_stall_o}, 1);
        chk({tag, ".if_ack"}, {31'd0, if_wb_ack_o}, 0);
        chk({tag, ".ls_ack"}, {31'd0, ls_wb_ack_o}, 0);
    endtask

    initial begin
        checks = 0; errors = 0; testcase = 0;
        rst_i = 1;
        if_wb_adr_i = 0; if_wb_dat_i = 32'h1111_0000; if_wb_we_i = 0; if_wb_sel_i = 4'hF;
        ls_wb_adr_i = 0; ls_wb_dat_i = 32'h2222_0000; ls_wb_we_i = 1; ls_wb_sel_i = 4'h3;
        wb_dat_i = 0;
        idle_inputs();
        #12;
        chk_idle("reset");
        step();
        rst_i = 0;

        // 1: IF alone
        testcase = 1;
        if_wb_cyc_i = 1; if_wb_stb_i = 1; if_wb_adr_i = 32'h100;
        #1;
        chk("t1.c0_if_stall", {31'd0, if_wb_stall_o}, 1);
        chk("t1.c0_stb", {31'd0, wb_stb_o}, 0);
        step();
        chk("t1.c1_stb", {31'd0, wb_stb_o}, 1);
        chk("t1.c1_cyc", {31'd0, wb_cyc_o}, 1);
        chk("t1.c1_adr", wb_adr_o, 32'h100);
        chk("t1.c1_dat", wb_dat_o, 32'h1111_0000);
        chk("t1.c1_sel", {28'd0, wb_sel_o}, 32'hF);
        chk("t1.c1_if_stall", {31'd0, if_wb_stall_o}, 0);
        chk("t1.c1_ls_stall", {31'd0, ls_wb_stall_o}, 1);
        step();
        if_wb_stb_i = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFE_0001;
        #1;
        chk("t1.c2_if_ack", {31'd0, if_wb_ack_o}, 1);
        chk("t1.c2_ls_ack", {31'd0, ls_wb_ack_o}, 0);
        chk("t1.c2_if_dat", if_wb_dat_o, 32'hCAFE_0001);
        chk("t1.c2_ls_stall", {31'd0, ls_wb_stall_o}, 1);
        step();
        wb_ack_i = 0; if_wb_cyc_i = 0;
        #1;
        chk("t1.c3_if_ack", {31'd0, if_wb_ack_o}, 0);
        step();
        chk_idle("t1.c4");

        // 2: tie from reset goes to LS, then alternation
        testcase = 2;
        do_reset();
        if_wb_cyc_i = 1; if_wb_stb_i = 1; if_wb_adr_i = 32'h200;
        ls_wb_cyc_i = 1; ls_wb_stb_i = 1; ls_wb_adr_i = 32'h300;
        #1;
        chk("t2.c0_if_stall", {31'd0, if_wb_stall_o}, 1);
        chk("t2.c0_ls_stall", {31'd0, ls_wb_stall_o}, 1);
        step();
        chk("t2.ls_adr", wb_adr_o, 32'h300);
        chk("t2.ls_we", {31'd0, wb_we_o}, 1);
        chk("t2.ls_stall", {31'd0, ls_wb_stall_o}, 0);
        chk("t2.if_stall", {31'd0, if_wb_stall_o}, 1);
        step();
        ls_wb_cyc_i = 0; ls_wb_stb_i = 0; wb_ack_i = 1;
        #1;
        chk("t2.n_ls_ack", {31'd0, ls_wb_ack_o}, 1);
        chk("t2.n_if_ack", {31'd0, if_wb_ack_o}, 0);
        step();
        wb_ack_i = 0;
        #1;
        chk("t2.n1_cyc", {31'd0, wb_cyc_o}, 0);
        chk("t2.n1_if_stall", {31'd0, if_wb_stall_o}, 1);
        step();
        chk("t2.n2_if_adr", wb_adr_o, 32'h200);
        chk("t2.n2_if_stall", {31'd0, if_wb_stall_o}, 0);
        chk("t2.n2_stb", {31'd0, wb_stb_o}, 1);
        if_wb_cyc_i = 0; if_wb_stb_i = 0;
        step();
        if_wb_cyc_i = 1; if_wb_stb_i = 1; ls_wb_cyc_i = 1; ls_wb_stb_i = 1;
        step();
        chk("t2.tie2_adr", wb_adr_o, 32'h300);
        chk("t2.tie2_ls_stall", {31'd0, ls_wb_stall_o}, 0);
        chk("t2.tie2_if_stall", {31'd0, if_wb_stall_o}, 1);

        // 3: fill to MAX_OUTSTANDING, one ack frees one slot
        testcase = 3;
        do_reset();
        ls_wb_cyc_i = 1; ls_wb_stb_i = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3.acc%0d_stb", i), {31'd0, wb_stb_o}, 1);
            chk($sformatf("t3.acc%0d_stall", i), {31'd0, ls_wb_stall_o}, 0);
            step();
        end
        chk("t3.full_stb", {31'd0, wb_stb_o}, 0);
        chk("t3.full_stall", {31'd0, ls_wb_stall_o}, 1);
        wb_ack_i = 1;
        #1;
        chk("t3.ack", {31'd0, ls_wb_ack_o}, 1);
        step();
        wb_ack_i = 0;
        #1;
        chk("t3.reopen_stb", {31'd0, wb_stb_o}, 1);
        step();
        chk("t3.refull_stb", {31'd0, wb_stb_o}, 0);
        chk("t3.refull_stall", {31'd0, ls_wb_stall_o}, 1);

        // 4: accept and ack together at count 2 leave the count unchanged
        testcase = 4;
        do_reset();
        ls_wb_cyc_i = 1; ls_wb_stb_i = 1;
        step();
        step();
        step();
        wb_ack_i = 1;
        #1;
        chk("t4.both_stb", {31'd0, wb_stb_o}, 1);
        step();
        wb_ack_i = 0;
        #1;
        chk("t4.acc3_stb", {31'd0, wb_stb_o}, 1);
        step();
        chk("t4.acc4_stb", {31'd0, wb_stb_o}, 1);
        chk("t4.acc4_stall", {31'd0, ls_wb_stall_o}, 0);
        step();
        chk("t4.full_stb", {31'd0, wb_stb_o}, 0);
        chk("t4.full_stall", {31'd0, ls_wb_stall_o}, 1);

        // 5: abort with 3 outstanding, stray ack dropped, IF starts with an empty counter
        testcase = 5;
        do_reset();
        ls_wb_cyc_i = 1; ls_wb_stb_i = 1;
        step();
        step();
        step();
        step();
        ls_wb_cyc_i = 0; ls_wb_stb_i = 0;
        step();
        if_wb_cyc_i = 1; if_wb_stb_i = 1; if_wb_adr_i = 32'h400; wb_ack_i = 1;
        #1;
        chk("t5.idle_cyc", {31'd0, wb_cyc_o}, 0);
        chk("t5.idle_if_ack", {31'd0, if_wb_ack_o}, 0);
        chk("t5.idle_ls_ack", {31'd0, ls_wb_ack_o}, 0);
        chk("t5.idle_ls_stall", {31'd0, ls_wb_stall_o}, 1);
        step();
        wb_ack_i = 0;
        #1;
        chk("t5.if_adr", wb_adr_o, 32'h400);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5.acc%0d_stb", i), {31'd0, wb_stb_o}, 1);
            step();
        end
        chk("t5.full_stb", {31'd0, wb_stb_o}, 0);
        chk("t5.full_if_stall", {31'd0, if_wb_stall_o}, 1);

        // 6: asynchronous reset mid-burst, then a clean IF transaction
        testcase = 6;
        do_reset();
        if_wb_cyc_i = 1; if_wb_stb_i = 1; if_wb_adr_i = 32'h500;
        step();
        step();
        wb_ack_i = 1;
        #1;
        chk("t6.pre_cyc", {31'd0, wb_cyc_o}, 1);
        rst_i = 1;
        #1;
        chk_idle("t6.rst");
        step();
        rst_i = 0;
        wb_ack_i = 0;
        if_wb_cyc_i = 0; if_wb_stb_i = 0;
        step();
        if_wb_cyc_i = 1; if_wb_stb_i = 1; if_wb_adr_i = 32'h600;
        #1;
        chk("t6.c0_if_stall", {31'd0, if_wb_stall_o}, 1);
        step();
        chk("t6.c1_adr", wb_adr_o, 32'h600);
        chk("t6.c1_stb", {31'd0, wb_stb_o}, 1);
        step();
        if_wb_stb_i = 0; wb_ack_i = 1; wb_dat_i = 32'hBEEF_0600;
        #1;
        chk("t6.c2_ack", {31'd0, if_wb_ack_o}, 1);
        chk("t6.c2_dat", if_wb_dat_o, 32'hBEEF_0600);
        step();
        wb_ack_i = 0; if_wb_cyc_i = 0;
        step();
        chk_idle("t6.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
